// File: rtl/magic_square_loader.sv
// Collects nine digits over valid/ready into a row-major 3x3 square and holds it
// until acknowledged, tracking repeated and out-of-range digits along the way.
module magic_square_loader #(
  parameter int W         = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] num_in,
  input  logic         num_valid,
  output logic         num_ready,
  input  logic         clear,
  input  logic         square_ack,
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic [W-1:0] num3,
  output logic [W-1:0] num4,
  output logic [W-1:0] num5,
  output logic [W-1:0] num6,
  output logic [W-1:0] num7,
  output logic [W-1:0] num8,
  output logic [W-1:0] num9,
  output logic         square_valid,
  output logic [3:0]   count,
  output logic         dup_seen,
  output logic         bad_digit
);

  typedef enum logic {LOAD, FULL} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   slot_reg  [9];
  logic [W-1:0]   slot_next [9];
  logic [3:0]     count_reg, count_next;
  logic [MAX_DIGIT:1] seen_reg, seen_next;
  logic           dup_reg, dup_next;
  logic           bad_reg, bad_next;
  logic           legal;

  assign legal = (num_in != '0) && (num_in <= W'(MAX_DIGIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LOAD;
      count_reg <= '0;
      seen_reg  <= '0;
      dup_reg   <= 1'b0;
      bad_reg   <= 1'b0;
      for (int i = 0; i < 9; i++) slot_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      seen_reg  <= seen_next;
      dup_reg   <= dup_next;
      bad_reg   <= bad_next;
      for (int i = 0; i < 9; i++) slot_reg[i] <= slot_next[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    seen_next  = seen_reg;
    dup_next   = dup_reg;
    bad_next   = bad_reg;
    for (int i = 0; i < 9; i++) slot_next[i] = slot_reg[i];

    // clear and release both return the loader to its empty state
    if (clear || (state_reg == FULL && square_ack)) begin
      state_next = LOAD;
      count_next = '0;
      seen_next  = '0;
      dup_next   = 1'b0;
      bad_next   = 1'b0;
      for (int i = 0; i < 9; i++) slot_next[i] = '0;
    end else if (state_reg == LOAD && num_valid) begin
      for (int i = 0; i < 9; i++) begin
        if (count_reg == 4'(i)) slot_next[i] = num_in;
      end
      count_next = 4'(count_reg + 4'd1);
      if (legal) begin
        for (int d = 1; d <= MAX_DIGIT; d++) begin
          if (num_in == W'(d)) begin
            if (seen_reg[d]) dup_next = 1'b1;
            seen_next[d] = 1'b1;
          end
        end
      end else begin
        bad_next = 1'b1;
      end
      if (count_reg == 4'd8) state_next = FULL;
    end
  end

  assign num_ready    = (state_reg == LOAD);
  assign square_valid = (state_reg == FULL);
  assign count        = count_reg;
  assign dup_seen     = dup_reg;
  assign bad_digit    = bad_reg;

  assign num1 = slot_reg[0];
  assign num2 = slot_reg[1];
  assign num3 = slot_reg[2];
  assign num4 = slot_reg[3];
  assign num5 = slot_reg[4];
  assign num6 = slot_reg[5];
  assign num7 = slot_reg[6];
  assign num8 = slot_reg[7];
  assign num9 = slot_reg[8];

endmodule
